// File: rtl/jt900h_cr_arb_pkg.sv
// Shared definitions for the control-register bus arbiter: state encodings
// and the default burst lock limit, also used by the micro-DMA engine.
package jt900h_cr_arb_pkg;

    typedef enum logic [1:0] {
        CRARB_IDLE  = 2'd0,
        CRARB_DMA   = 2'd1,
        CRARB_FLUSH = 2'd2
    } crarb_state_e;

    localparam int CRARB_LOCKMAX = 8;

endpackage

// File: rtl/jt900h_cr_arb.sv
// Control-register bus arbiter between the CPU register unit and the micro-DMA.
// CPU writes during a DMA burst are posted in a one-entry buffer and flushed afterwards.
module jt900h_cr_arb
    import jt900h_cr_arb_pkg::*;
#(
    parameter int LOCKMAX = CRARB_LOCKMAX,
    parameter int CW      = $clog2(LOCKMAX + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [7:0]  cpu_cra,
    input  logic [31:0] cpu_crin,
    input  logic        cpu_we,
    input  logic        cpu_rd,
    output logic [31:0] cpu_cr,
    output logic        cpu_wait,
    input  logic        dma_req,
    input  logic        dma_lock,
    output logic        dma_gnt,
    input  logic [7:0]  dma_cra,
    input  logic [31:0] dma_crin,
    input  logic        dma_we,
    input  logic        dma_rd,
    output logic [31:0] dma_cr,
    output logic [7:0]  mmr_a,
    output logic [31:0] mmr_din,
    output logic        mmr_we,
    output logic        mmr_rd,
    input  logic [31:0] mmr_dout
);

    localparam logic [CW-1:0] LOCK_C = CW'(LOCKMAX);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    crarb_state_e  state_q, state_d;
    logic          pend_q, pend_d;
    logic [7:0]    buf_a_q, buf_a_d;
    logic [31:0]   buf_d_q, buf_d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          block_q, block_d;
    logic          waiting_s;
    logic          forced_s;

    assign waiting_s = pend_q | cpu_rd;
    // The cap trips on the edge that brings the wait count to LOCKMAX, so the
    // CPU never waits more than LOCKMAX cen cycles inside a burst.
    assign forced_s  = (cnt_q == LOCK_C) | (waiting_s & (cnt_q == LOCK_C - ONE_C));

    // State, posted-write buffer, burst counter and post-cap grant block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CRARB_IDLE;
            pend_q  <= 1'b0;
            buf_a_q <= 8'd0;
            buf_d_q <= 32'd0;
            cnt_q   <= '0;
            block_q <= 1'b0;
        end else if (cen) begin
            state_q <= state_d;
            pend_q  <= pend_d;
            buf_a_q <= buf_a_d;
            buf_d_q <= buf_d_d;
            cnt_q   <= cnt_d;
            block_q <= block_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        buf_a_d = buf_a_q;
        buf_d_d = buf_d_q;
        cnt_d   = cnt_q;
        block_d = block_q;
        case (state_q)
            CRARB_IDLE: begin
                // Any CPU cycle in IDLE (access or idle) lifts the post-cap block
                block_d = 1'b0;
                if (dma_req && !cpu_we && !cpu_rd && !block_q) begin
                    state_d = CRARB_DMA;
                    cnt_d   = '0;
                end else begin
                    state_d = CRARB_IDLE;
                end
            end
            CRARB_DMA: begin
                if (cpu_we) begin
                    pend_d  = 1'b1;
                    buf_a_d = cpu_cra;
                    buf_d_d = cpu_crin;
                end else begin
                    pend_d  = pend_q;
                end
                if (waiting_s && (cnt_q != LOCK_C)) begin
                    cnt_d = cnt_q + ONE_C;
                end else begin
                    cnt_d = cnt_q;
                end
                if ((!dma_lock && !dma_req) || forced_s) begin
                    state_d = pend_d ? CRARB_FLUSH : CRARB_IDLE;
                    block_d = forced_s;
                end else begin
                    state_d = CRARB_DMA;
                end
            end
            CRARB_FLUSH: begin
                pend_d  = 1'b0;
                state_d = CRARB_IDLE;
            end
            default: begin
                state_d = CRARB_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // MMR bus mux
    always_comb begin
        mmr_a   = cpu_cra;
        mmr_din = cpu_crin;
        mmr_we  = 1'b0;
        mmr_rd  = 1'b0;
        case (state_q)
            CRARB_IDLE: begin
                mmr_a   = cpu_cra;
                mmr_din = cpu_crin;
                mmr_we  = cpu_we;
                mmr_rd  = cpu_rd;
            end
            CRARB_DMA: begin
                mmr_a   = dma_cra;
                mmr_din = dma_crin;
                mmr_we  = dma_we & dma_gnt;
                mmr_rd  = dma_rd & dma_gnt;
            end
            CRARB_FLUSH: begin
                mmr_a   = buf_a_q;
                mmr_din = buf_d_q;
                mmr_we  = 1'b1;
                mmr_rd  = 1'b0;
            end
            default: begin
                mmr_we  = 1'b0;
                mmr_rd  = 1'b0;
            end
        endcase
    end

    assign dma_gnt  = (state_q == CRARB_DMA);
    assign cpu_wait = ((state_q == CRARB_DMA) & waiting_s) | (state_q == CRARB_FLUSH);
    assign cpu_cr   = mmr_dout;
    assign dma_cr   = mmr_dout;

endmodule

// File: tb/tb_jt900h_cr_arb.sv
// Directed self-checking bench for jt900h_cr_arb.
module tb_jt900h_cr_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic [7:0]  cpu_cra = 8'd0;
    logic [31:0] cpu_crin = 32'd0;
    logic        cpu_we = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [31:0] cpu_cr;
    logic        cpu_wait;
    logic        dma_req = 1'b0;
    logic        dma_lock = 1'b0;
    logic        dma_gnt;
    logic [7:0]  dma_cra = 8'd0;
    logic [31:0] dma_crin = 32'd0;
    logic        dma_we = 1'b0;
    logic        dma_rd = 1'b0;
    logic [31:0] dma_cr;
    logic [7:0]  mmr_a;
    logic [31:0] mmr_din;
    logic        mmr_we;
    logic        mmr_rd;
    logic [31:0] mmr_dout;

    int checks = 0;
    int failures = 0;
    logic [39:0] wlog[$];

    jt900h_cr_arb dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_cra(cpu_cra), .cpu_crin(cpu_crin), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
        .cpu_cr(cpu_cr), .cpu_wait(cpu_wait),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
        .dma_cra(dma_cra), .dma_crin(dma_crin), .dma_we(dma_we), .dma_rd(dma_rd),
        .dma_cr(dma_cr),
        .mmr_a(mmr_a), .mmr_din(mmr_din), .mmr_we(mmr_we), .mmr_rd(mmr_rd),
        .mmr_dout(mmr_dout)
    );

    always #5 clk = ~clk;

    // MMR file model: read data is the address replicated in every byte
    assign mmr_dout = {mmr_a, mmr_a, mmr_a, mmr_a};

    always @(posedge clk) begin
        if (cen && mmr_we && !rst) wlog.push_back({mmr_a, mmr_din});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        cpu_cra = 8'h11;
        #1;
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%0h exp=0", dma_gnt); end
        checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL rst_wait got=%0h exp=0", cpu_wait); end
        checks++; if (mmr_we !== 1'b0) begin failures++; $display("FAIL rst_mmr_we got=%0h exp=0", mmr_we); end
        checks++; if (mmr_a !== 8'h11) begin failures++; $display("FAIL rst_mmr_a got=%0h exp=11", mmr_a); end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_cpu_only();
        cpu_we = 1'b1; cpu_cra = 8'h20; cpu_crin = 32'h12345678;
        #1;
        checks++; if (mmr_we !== 1'b1) begin failures++; $display("FAIL cpu_mmr_we got=%0h exp=1", mmr_we); end
        checks++; if (mmr_a !== 8'h20) begin failures++; $display("FAIL cpu_mmr_a got=%0h exp=20", mmr_a); end
        checks++; if (mmr_din !== 32'h12345678) begin failures++; $display("FAIL cpu_mmr_din got=%0h exp=12345678", mmr_din); end
        checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL cpu_wait got=%0h exp=0", cpu_wait); end
        tick();
        cpu_we = 1'b0; cpu_rd = 1'b1; cpu_cra = 8'h44;
        #1;
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL cpu_gnt got=%0h exp=0", dma_gnt); end
        checks++; if (mmr_rd !== 1'b1) begin failures++; $display("FAIL cpu_mmr_rd got=%0h exp=1", mmr_rd); end
        checks++; if (cpu_cr !== 32'h44444444) begin failures++; $display("FAIL cpu_rdata got=%0h exp=44444444", cpu_cr); end
        tick();
        cpu_rd = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        wlog.delete();
        dma_req = 1'b1; dma_lock = 1'b1;
        #1;
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL burst_gnt_early got=%0h exp=0", dma_gnt); end
        tick();
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL burst_gnt got=%0h exp=1", dma_gnt); end
        for (int i = 0; i < 5; i++) begin
            dma_we = 1'b1; dma_cra = 8'hA0 + 8'(i); dma_crin = 32'h10000000 + 32'(i);
            #1;
            checks++; if (mmr_a !== 8'hA0 + 8'(i) || mmr_we !== 1'b1) begin failures++; $display("FAIL burst_mux%0d got=%0h/%0h exp=%0h/1", i, mmr_a, mmr_we, 8'hA0 + 8'(i)); end
            tick();
        end
        dma_we = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        #1;
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL burst_gnt_hold got=%0h exp=1", dma_gnt); end
        tick();
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL burst_gnt_fall got=%0h exp=0", dma_gnt); end
        checks++; if (wlog.size() != 5) begin failures++; $display("FAIL burst_count got=%0d exp=5", wlog.size()); end
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            checks++; if (wlog[i] !== {8'hA0 + 8'(i), 32'h10000000 + 32'(i)}) begin failures++; $display("FAIL burst_w%0d got=%0h", i, wlog[i]); end
        end
    endtask

    task automatic test_posted();
        wlog.delete();
        dma_req = 1'b1; dma_lock = 1'b1;
        tick();
        dma_we = 1'b1; dma_cra = 8'hB0; dma_crin = 32'hB0B0;
        cpu_we = 1'b1; cpu_cra = 8'h30; cpu_crin = 32'hDEAD;
        #1;
        checks++; if (cpu_wait !== 1'b0 || mmr_a !== 8'hB0) begin failures++; $display("FAIL post_first got=%0h/%0h exp=0/b0", cpu_wait, mmr_a); end
        tick();
        cpu_we = 1'b0; dma_we = 1'b0; cpu_cra = 8'h00; cpu_crin = 32'd0;
        #1;
        checks++; if (cpu_wait !== 1'b1) begin failures++; $display("FAIL post_wait got=%0h exp=1", cpu_wait); end
        tick();
        dma_req = 1'b0; dma_lock = 1'b0;
        #1;
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL post_gnt got=%0h exp=1", dma_gnt); end
        tick();
        checks++; if (dma_gnt !== 1'b0 || cpu_wait !== 1'b1) begin failures++; $display("FAIL flush_ctl got=%0h/%0h exp=0/1", dma_gnt, cpu_wait); end
        checks++; if (mmr_a !== 8'h30 || mmr_din !== 32'hDEAD || mmr_we !== 1'b1 || mmr_rd !== 1'b0) begin failures++; $display("FAIL flush_bus got=%0h/%0h/%0h/%0h exp=30/dead/1/0", mmr_a, mmr_din, mmr_we, mmr_rd); end
        tick();
        checks++; if (cpu_wait !== 1'b0 || mmr_we !== 1'b0) begin failures++; $display("FAIL post_idle got=%0h/%0h exp=0/0", cpu_wait, mmr_we); end
        checks++; if (wlog.size() != 2 || wlog[0] !== {8'hB0, 32'hB0B0} || wlog[1] !== {8'h30, 32'hDEAD}) begin failures++; $display("FAIL post_order got size=%0d", wlog.size()); end
    endtask

    task automatic test_starvation();
        int waited;
        dma_req = 1'b1; dma_lock = 1'b1;
        tick();
        tick();
        cpu_rd = 1'b1; cpu_cra = 8'h55;
        #1;
        waited = 0;
        while (dma_gnt === 1'b1 && waited < 20) begin
            waited++;
            tick();
        end
        checks++; if (waited != 8) begin failures++; $display("FAIL cap_rd_cycles got=%0d exp=8", waited); end
        checks++; if (cpu_wait !== 1'b0 || cpu_cr !== 32'h55555555) begin failures++; $display("FAIL cap_read got=%0h/%0h exp=0/55555555", cpu_wait, cpu_cr); end
        tick();
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL cap_no_regrant got=%0h exp=0", dma_gnt); end
        cpu_rd = 1'b0;
        tick();
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL cap_regrant got=%0h exp=1", dma_gnt); end
        dma_req = 1'b0; dma_lock = 1'b0;
        tick();
        // Cap driven by a posted write, then the post-cap block on an idle CPU
        dma_req = 1'b1; dma_lock = 1'b1;
        tick();
        cpu_we = 1'b1; cpu_cra = 8'h31; cpu_crin = 32'hBEEF;
        tick();
        cpu_we = 1'b0;
        #1;
        waited = 0;
        while (dma_gnt === 1'b1 && waited < 20) begin
            waited++;
            tick();
        end
        checks++; if (waited != 8) begin failures++; $display("FAIL cap_wr_cycles got=%0d exp=8", waited); end
        checks++; if (mmr_a !== 8'h31 || mmr_din !== 32'hBEEF || mmr_we !== 1'b1) begin failures++; $display("FAIL cap_flush got=%0h/%0h/%0h exp=31/beef/1", mmr_a, mmr_din, mmr_we); end
        tick();
        checks++; if (dma_gnt !== 1'b0 || cpu_wait !== 1'b0) begin failures++; $display("FAIL cap_idle got=%0h/%0h exp=0/0", dma_gnt, cpu_wait); end
        tick();
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL cap_block got=%0h exp=0", dma_gnt); end
        tick();
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL cap_unblock got=%0h exp=1", dma_gnt); end
        dma_req = 1'b0; dma_lock = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        cpu_rd = 1'b1; cpu_cra = 8'h66; dma_req = 1'b1;
        #1;
        checks++; if (dma_gnt !== 1'b0 || mmr_rd !== 1'b1 || cpu_cr !== 32'h66666666) begin failures++; $display("FAIL sim_cpu got=%0h/%0h/%0h exp=0/1/66666666", dma_gnt, mmr_rd, cpu_cr); end
        tick();
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL sim_hold got=%0h exp=0", dma_gnt); end
        cpu_rd = 1'b0;
        tick();
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL sim_grant got=%0h exp=1", dma_gnt); end
        dma_req = 1'b0;
        tick();
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL sim_release got=%0h exp=0", dma_gnt); end
    endtask

    task automatic test_cen_hold();
        cen = 1'b0; dma_req = 1'b1;
        tick();
        tick();
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL cen_hold got=%0h exp=0", dma_gnt); end
        cen = 1'b1;
        tick();
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL cen_go got=%0h exp=1", dma_gnt); end
        dma_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dma_req = 1'b1; dma_lock = 1'b1;
        tick();
        cpu_we = 1'b1; cpu_cra = 8'h77; cpu_crin = 32'h7777;
        tick();
        cpu_we = 1'b0; cpu_cra = 8'h00;
        #1;
        checks++; if (cpu_wait !== 1'b1 || dma_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%0h/%0h exp=1/1", cpu_wait, dma_gnt); end
        #1 rst = 1'b1;
        #1;
        checks++; if (dma_gnt !== 1'b0 || cpu_wait !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%0h/%0h exp=0/0", dma_gnt, cpu_wait); end
        dma_req = 1'b0; dma_lock = 1'b0;
        #1 rst = 1'b0;
        wlog.delete();
        tick();
        tick();
        tick();
        checks++; if (wlog.size() != 0) begin failures++; $display("FAIL rstmid_noflush got=%0d writes exp=0", wlog.size()); end
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_burst();
        test_posted();
        test_starvation();
        test_simultaneous();
        test_cen_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
